pulp_clock_div_serv: RTL and testbench

- Parametrised, glitch-free, run-time programmable integer clock divider on a single source clock.
- Generates a divided clock from `clk_i`, or passes `clk_i` straight through in bypass.
- Ratio changes, enable/disable and bypass entry/exit happen only at period boundaries, so `clk_o` never emits a runt pulse.
- Sits between the SoC reference clock and the SERV core/peripheral clock domains; successor to the 2:1 static clock mux.

---
 rtl/pulp_clock_div_serv.sv | 154 +++++++++++++++
 tb/tb_pulp_clock_div_serv.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pulp_clock_div_serv.sv
// pulp_clock_div_serv
//   Glitch-free, run-time programmable integer clock divider on clk_i.
//   A ratio of 0 or 1 selects bypass (clk_o follows clk_i). A ratio N >= 2
//   gives a period of N clk_i cycles: ceil(N/2) cycles high, then floor(N/2)
//   cycles low. Ratio changes, enable/disable and bypass entry/exit take
//   effect only at period boundaries, so clk_o never emits a runt pulse.
//
//   Optional feature, macro PULP_CLK_DIV_ODD50_EN: a clk_i negedge flop
//   stretches the high phase by half a cycle for odd N >= 3, giving 50% duty.
//   In that build the posedge phase is floor(N/2) cycles high. Boundaries and
//   ack timing do not change.
//
// Ports:
//   clk_i        source clock
//   rst_ni       asynchronous active-low reset
//   test_mode_i  DFT override, forces clk_o = clk_i (combinational only)
//   clk_en_i     output enable; low parks clk_o low at the next boundary
//   div_i        requested ratio; stable while div_valid_i is high
//   div_valid_i  ratio-change request, held high until div_ack_o
//   div_ack_o    one-cycle pulse: requested ratio now in force
//   clk_o        divided, bypassed or parked clock
module pulp_clock_div_serv #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_mode_i,
  input  logic             clk_en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_valid_i,
  output logic             div_ack_o,
  output logic             clk_o
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W:0]   ONE_X   = (DIV_W+1)'(1);
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic             DEF_BYP = (DEFAULT_DIV <= 1);
  // In divided mode the counter resets to the boundary value, so the first
  // posedge after reset release starts a fresh period.
  localparam logic [DIV_W-1:0] DEF_CNT = DEF_BYP ? '0 : DEF_DIV - ONE;

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             byp_q, byp_d;
  logic             ack_q, ack_d;

  logic             at_bnd;
  logic             req;
  logic             new_byp;
  logic             clk_div;

  // Number of posedge-phase high cycles for ratio n.
  function automatic logic [DIV_W:0] hi_len(input logic [DIV_W-1:0] n);
`ifdef PULP_CLK_DIV_ODD50_EN
    return {1'b0, n} >> 1;
`else
    return ({1'b0, n} + ONE_X) >> 1;
`endif
  endfunction

  assign at_bnd  = (cnt_q == (div_q - ONE));
  // ack_q blocks a still-held div_valid_i from being accepted back to back.
  assign req     = div_valid_i & ~ack_q;
  assign new_byp = (div_i <= ONE);

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    clk_d = clk_q;
    byp_d = byp_q;
    ack_d = 1'b0;
    if (byp_q) begin
      // Enable is ignored in bypass. Leaving bypass happens on a posedge, when
      // clk_i is already high, so raising clk_q at the same edge is seamless.
      if (req) begin
        div_d = div_i;
        ack_d = 1'b1;
        if (!new_byp) begin
          byp_d = 1'b0;
          cnt_d = '0;
          clk_d = 1'b1;
        end
      end
    end else if (at_bnd) begin
      // clk_q is low in the last cycle of every period, so switching to
      // bypass here lets clk_o rise together with clk_i.
      if (req) begin
        div_d = div_i;
        ack_d = 1'b1;
        if (new_byp) begin
          byp_d = 1'b1;
          cnt_d = '0;
          clk_d = 1'b0;
        end else if (clk_en_i) begin
          cnt_d = '0;
          clk_d = 1'b1;
        end else begin
          cnt_d = div_i - ONE;
          clk_d = 1'b0;
        end
      end else if (clk_en_i) begin
        cnt_d = '0;
        clk_d = 1'b1;
      end else begin
        // Parked: counter stays on the boundary value, clock stays low.
        clk_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + ONE;
      clk_d = (({1'b0, cnt_q} + ONE_X) < hi_len(div_q));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= DEF_DIV;
      cnt_q <= DEF_CNT;
      clk_q <= 1'b0;
      byp_q <= DEF_BYP;
      ack_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      clk_q <= clk_d;
      byp_q <= byp_d;
      ack_q <= ack_d;
    end
  end

`ifdef PULP_CLK_DIV_ODD50_EN
  logic clk_neg_q;

  // Re-times clk_q onto the falling edge; ORed in, it holds clk_o high for
  // half a cycle past the fall of clk_q when the ratio is odd.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_neg_q <= 1'b0;
    end else begin
      clk_neg_q <= clk_q & div_q[0] & ~byp_q;
    end
  end

  assign clk_div = clk_q | clk_neg_q;
`else
  assign clk_div = clk_q;
`endif

  assign clk_o     = (test_mode_i | byp_q) ? clk_i : clk_div;
  assign div_ack_o = ack_q;

endmodule

// File: tb/tb_pulp_clock_div_serv.sv
module tb_pulp_clock_div_serv;

  logic       clk_i;
  logic       rst_ni;
  logic       test_mode_i;
  logic       clk_en_i;
  logic [7:0] div_i;
  logic       div_valid_i;
  logic       div_ack_o;
  logic       clk_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] div;
    logic       exp_clk;   // clk_o in the high phase of clk_i after the edge
    logic       exp_ack;
    logic       exp_byp;   // bypass: clk_o low in the clk_i low phase
  } vec_t;

  typedef struct {
    logic clk;
    logic ack;
    logic byp;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  pulp_clock_div_serv #(.DIV_W(8), .DEFAULT_DIV(1)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .test_mode_i(test_mode_i),
    .clk_en_i   (clk_en_i),
    .div_i      (div_i),
    .div_valid_i(div_valid_i),
    .div_ack_o  (div_ack_o),
    .clk_o      (clk_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic v, input logic [7:0] d,
                     input logic c, input logic a, input logic b);
    vec_t r;
    r.en = en; r.valid = v; r.div = d;
    r.exp_clk = c; r.exp_ack = a; r.exp_byp = b;
    vecs.push_back(r);
  endtask

  // Called in the clk_i low phase: drive, queue expectation, check after the
  // next posedge and again in the following low phase.
  task automatic apply_row(input string tag, input vec_t r);
    exp_t e;
    exp_t got;
    clk_en_i    = r.en;
    div_valid_i = r.valid;
    div_i       = r.div;
    e.clk = r.exp_clk; e.ack = r.exp_ack; e.byp = r.exp_byp;
    exp_q.push_back(e);
    @(posedge clk_i);
    #2;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 1'b1, 1'b0);
    end else begin
      got = exp_q.pop_front();
      chk({tag, " clk_hi"}, clk_o, got.clk);
      chk({tag, " ack"}, div_ack_o, got.ack);
      @(negedge clk_i);
      #2;
      chk({tag, " clk_lo"}, clk_o, got.byp ? 1'b0 : got.clk);
    end
  endtask

  initial begin
    vec_t r;
    rst_ni      = 1'b0;
    test_mode_i = 1'b0;
    clk_en_i    = 1'b1;
    div_i       = 8'd0;
    div_valid_i = 1'b0;

    // en, valid, div, clk_hi, ack, byp
    add(1,0,0, 1,0,1); add(1,0,0, 1,0,1);
    add(1,1,4, 1,1,0);                                     // bypass -> N=4
    add(1,0,4, 1,0,0); add(1,0,4, 0,0,0); add(1,0,4, 0,0,0);
    add(1,0,4, 1,0,0); add(1,0,4, 1,0,0);
    add(0,0,4, 0,0,0); add(0,0,4, 0,0,0);                  // enable dropped at cnt 1
    add(0,0,4, 0,0,0); add(0,0,4, 0,0,0);                  // parked
    add(1,0,4, 1,0,0); add(1,0,4, 1,0,0); add(1,0,4, 0,0,0); add(1,0,4, 0,0,0);
    add(1,1,3, 1,1,0);                                     // N=3 at boundary
    add(1,0,3, 1,0,0); add(1,0,3, 0,0,0); add(1,0,3, 1,0,0);
    add(1,1,5, 1,0,0); add(1,1,5, 0,0,0);                  // pending, old 2/1 kept
    add(1,1,5, 1,1,0);                                     // N=5 applied
    add(1,0,5, 1,0,0); add(1,0,5, 1,0,0); add(1,0,5, 0,0,0); add(1,0,5, 0,0,0);
    add(1,0,5, 1,0,0);
    add(1,1,5, 1,0,0); add(1,1,5, 1,0,0); add(1,1,5, 0,0,0); add(1,1,5, 0,0,0);
    add(1,1,5, 1,1,0);                                     // same ratio still acked
    add(1,1,5, 1,0,0); add(1,1,5, 1,0,0);
    add(1,0,5, 0,0,0); add(1,0,5, 0,0,0); add(1,0,5, 1,0,0);
    add(1,1,6, 1,0,0); add(1,1,6, 1,0,0); add(1,1,6, 0,0,0); add(1,1,6, 0,0,0);
    add(1,1,6, 1,1,0);                                     // N=6 applied
    add(1,0,6, 1,0,0); add(1,0,6, 1,0,0); add(1,0,6, 0,0,0); add(1,0,6, 0,0,0);
    add(1,1,0, 0,0,0);                                     // request bypass, pending
    add(1,1,0, 1,1,1);                                     // bypass at boundary
    add(1,1,0, 1,0,1);                                     // held valid blocked one cycle
    add(1,1,0, 1,1,1);                                     // then accepted again
    add(0,0,0, 1,0,1);                                     // enable ignored in bypass
    add(0,1,2, 1,1,0);                                     // N=2 starts even with en low
    add(0,0,2, 0,0,0); add(0,0,2, 0,0,0); add(0,0,2, 0,0,0);
    add(1,0,2, 1,0,0); add(1,0,2, 0,0,0);

    // Reset state: bypass default, clk_o follows clk_i, no ack.
    repeat (2) @(posedge clk_i);
    #2;
    chk("reset clk_hi", clk_o, 1'b1);
    chk("reset ack", div_ack_o, 1'b0);
    @(negedge clk_i);
    #2;
    chk("reset clk_lo", clk_o, 1'b0);
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      r = vecs[i];
      apply_row($sformatf("row%0d", i + 1), r);
    end

    // Test mode overrides the divided clock; counter keeps running beneath.
    test_mode_i = 1'b1;
    #1;
    chk("tm lo", clk_o, clk_i);
    @(posedge clk_i);
    #2;
    chk("tm hi", clk_o, 1'b1);
    @(negedge clk_i);
    #2;
    chk("tm lo2", clk_o, 1'b0);
    test_mode_i = 1'b0;
    #1;
    chk("tm off underlying", clk_o, 1'b1);

    // N=2 at cnt 0: request N=4 waits one cycle for the boundary.
    r.en = 1; r.valid = 1; r.div = 8'd4; r.exp_clk = 0; r.exp_ack = 0; r.exp_byp = 0;
    apply_row("seq_a", r);
    r.exp_clk = 1; r.exp_ack = 1;
    apply_row("seq_b", r);
    r.valid = 0; r.exp_ack = 0;
    apply_row("seq_c", r);

    // Reset mid-period in the clk_i low phase with a new request pending.
    div_i       = 8'd6;
    div_valid_i = 1'b1;
    chk("pre_rst clk", clk_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("rst clk_now", clk_o, 1'b0);
    chk("rst ack_now", div_ack_o, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_i);
      #2;
      chk($sformatf("rst%0d clk_hi", k), clk_o, 1'b1);
      chk($sformatf("rst%0d ack", k), div_ack_o, 1'b0);
    end
    @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    r.en = 1; r.valid = 0; r.div = 8'd0; r.exp_clk = 1; r.exp_ack = 0; r.exp_byp = 1;
    apply_row("post_rst0", r);
    apply_row("post_rst1", r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
